// File: rtl/req_ack_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | req_ack_checker: multi-channel req/ack pulse handshake protocol monitor    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module req_ack_checker #(
  parameter int NCH       = 4,
  parameter int DW        = 32,
  parameter int MIN_LAT   = 1,
  parameter int MAX_LAT   = 8,
  parameter int HOLD_DATA = 1,
  parameter int ONE_ACK   = 1,
  parameter int CNTW      = 16
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              enable,
  input  logic              clr_err,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    ack,
  input  logic [NCH*DW-1:0] data,
  output logic [NCH-1:0]    outstanding,
  output logic [NCH-1:0]    err_pulse,
  output logic [NCH*3-1:0]  err_code,
  output logic [NCH-1:0]    err_sticky,
  output logic              amone_err,
  output logic [CNTW-1:0]   err_count,
  output logic [CNTW-1:0]   done_count
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam int         c_incw       = $clog2(NCH + 2);
  localparam int         c_sumw       = CNTW + c_incw;
  localparam logic [7:0] c_min_lat    = 8'(MIN_LAT);
  localparam logic [7:0] c_max_lat    = 8'(MAX_LAT);
  localparam logic [2:0] c_ack_no_req = 3'd1;
  localparam logic [2:0] c_double_req = 3'd2;
  localparam logic [2:0] c_early_ack  = 3'd3;
  localparam logic [2:0] c_timeout    = 3'd4;
  localparam logic [2:0] c_data_chg   = 3'd5;

  logic [NCH-1:0]    w_err_src;
  logic [NCH-1:0]    w_done;
  logic [NCH-1:0]    w_wait_nxt;
  logic [NCH*3-1:0]  w_code_all;
  logic              w_amone;
  logic [c_incw-1:0] w_err_inc;
  logic [c_incw-1:0] w_done_inc;

  generate
    for (genvar n = 0; n < NCH; n++) begin : g_ch
      state_t        r_state;
      state_t        w_state_nxt;
      logic [7:0]    r_lat;
      logic [7:0]    w_lat_nxt;
      logic [DW-1:0] r_cap;
      logic [DW-1:0] w_data;
      logic          r_chg_seen;
      logic          w_chg_seen_nxt;
      logic          w_capture;
      logic          w_done_ch;
      logic [2:0]    w_code;

      assign w_data = data[n*DW +: DW];

      always_comb begin
        w_state_nxt    = r_state;
        w_lat_nxt      = r_lat;
        w_chg_seen_nxt = r_chg_seen;
        w_capture      = 1'b0;
        w_done_ch      = 1'b0;
        w_code         = 3'd0;
        if (!enable) begin
          w_state_nxt    = ST_IDLE;
          w_lat_nxt      = 8'd0;
          w_chg_seen_nxt = 1'b0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (req[n]) begin
                w_state_nxt    = ST_WAIT;
                w_lat_nxt      = 8'd1;
                w_capture      = 1'b1;
                w_chg_seen_nxt = 1'b0;
              end else if (ack[n]) begin
                w_code = c_ack_no_req;
              end
            end
            ST_WAIT: begin
              if (ack[n]) begin
                if (r_lat < c_min_lat) w_code = c_early_ack;
                else                   w_done_ch = 1'b1;
                // A req alongside the ack opens the next transaction immediately
                if (req[n]) begin
                  w_lat_nxt      = 8'd1;
                  w_capture      = 1'b1;
                  w_chg_seen_nxt = 1'b0;
                end else begin
                  w_state_nxt = ST_IDLE;
                  w_lat_nxt   = 8'd0;
                end
              end else if (r_lat == c_max_lat) begin
                w_code         = c_timeout;
                w_state_nxt    = ST_IDLE;
                w_lat_nxt      = 8'd0;
                w_chg_seen_nxt = 1'b0;
              end else begin
                w_lat_nxt = r_lat + 8'd1;
                if (req[n]) begin
                  w_code = c_double_req;
                end else if ((HOLD_DATA != 0) && (w_data != r_cap) && !r_chg_seen) begin
                  w_code         = c_data_chg;
                  w_chg_seen_nxt = 1'b1;
                end
              end
            end
            default: w_state_nxt = ST_IDLE;
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (!reset_l) begin
          r_state    <= ST_IDLE;
          r_lat      <= 8'd0;
          r_cap      <= '0;
          r_chg_seen <= 1'b0;
        end else begin
          r_state    <= w_state_nxt;
          r_lat      <= w_lat_nxt;
          r_chg_seen <= w_chg_seen_nxt;
          if (w_capture) r_cap <= w_data;
        end
      end

      assign w_code_all[n*3 +: 3] = w_code;
      assign w_err_src[n]         = (w_code != 3'd0);
      assign w_done[n]            = w_done_ch;
      assign w_wait_nxt[n]        = (w_state_nxt == ST_WAIT);
    end
  endgenerate

  assign w_amone    = enable && (ONE_ACK != 0) && ($countones(ack) > 1);
  assign w_err_inc  = c_incw'($countones(w_err_src)) + c_incw'(w_amone);
  assign w_done_inc = c_incw'($countones(w_done));

  function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0]   base,
                                              input logic [c_incw-1:0] inc);
    logic [c_sumw-1:0] sum;
    sum = c_sumw'(base) + c_sumw'(inc);
    if (sum[c_sumw-1:CNTW] != '0) sat_add = '1;
    else                          sat_add = sum[CNTW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      outstanding <= '0;
      err_pulse   <= '0;
      err_code    <= '0;
      err_sticky  <= '0;
      amone_err   <= 1'b0;
      err_count   <= '0;
      done_count  <= '0;
    end else begin
      outstanding <= w_wait_nxt;
      err_pulse   <= w_err_src;
      err_code    <= w_code_all;
      amone_err   <= w_amone;
      // A fresh error arriving with clr_err survives the clear
      if (enable) begin
        if (clr_err) begin
          err_sticky <= w_err_src;
          err_count  <= sat_add('0, w_err_inc);
        end else begin
          err_sticky <= err_sticky | w_err_src;
          err_count  <= sat_add(err_count, w_err_inc);
        end
        done_count <= sat_add(done_count, w_done_inc);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_req_ack_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_req_ack_checker: directed + random stimulus against a cycle-age model   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_req_ack_checker;
  localparam int NCH     = 4;
  localparam int DW      = 32;
  localparam int MIN_LAT = 2;
  localparam int MAX_LAT = 8;
  localparam int CNTW    = 16;
  localparam int CNTW_S  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_l, enable, clr_err;
  logic [NCH-1:0]    req, ack;
  logic [NCH*DW-1:0] data;

  logic [NCH-1:0]    out_a, pulse_a, sticky_a;
  logic [NCH*3-1:0]  code_a;
  logic              amone_a;
  logic [CNTW-1:0]   errc_a, donec_a;

  logic [NCH-1:0]    out_b, pulse_b, sticky_b;
  logic [NCH*3-1:0]  code_b;
  logic              amone_b;
  logic [CNTW_S-1:0] errc_b, donec_b;

  req_ack_checker #(.NCH(NCH), .DW(DW), .MIN_LAT(MIN_LAT), .MAX_LAT(MAX_LAT),
                    .HOLD_DATA(1), .ONE_ACK(1), .CNTW(CNTW)) dut_a (
    .clk(clk), .reset_l(reset_l), .enable(enable), .clr_err(clr_err),
    .req(req), .ack(ack), .data(data),
    .outstanding(out_a), .err_pulse(pulse_a), .err_code(code_a),
    .err_sticky(sticky_a), .amone_err(amone_a),
    .err_count(errc_a), .done_count(donec_a));

  req_ack_checker #(.NCH(NCH), .DW(DW), .MIN_LAT(MIN_LAT), .MAX_LAT(MAX_LAT),
                    .HOLD_DATA(1), .ONE_ACK(1), .CNTW(CNTW_S)) dut_b (
    .clk(clk), .reset_l(reset_l), .enable(enable), .clr_err(clr_err),
    .req(req), .ack(ack), .data(data),
    .outstanding(out_b), .err_pulse(pulse_b), .err_code(code_b),
    .err_sticky(sticky_b), .amone_err(amone_b),
    .err_count(errc_b), .done_count(donec_b));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a transaction is tracked by the cycle number of its req
  bit            m_busy[NCH];
  longint        m_start[NCH];
  logic [DW-1:0] m_cap[NCH];
  bit            m_seen[NCH];
  longint        cyc = 0;
  logic [NCH-1:0]   e_out, e_pulse, e_sticky;
  logic [NCH*3-1:0] e_code;
  logic             e_amone;
  longint           e_err, e_done, e_err_s, e_done_s;

  function automatic longint sat_val(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_busy[c] = 0; m_start[c] = 0; m_cap[c] = '0; m_seen[c] = 0;
    end
    e_out = '0; e_pulse = '0; e_sticky = '0; e_code = '0; e_amone = 1'b0;
    e_err = 0; e_done = 0; e_err_s = 0; e_done_s = 0;
  endtask

  task automatic model_edge();
    int         inc_e, inc_d;
    longint     age;
    logic [2:0] code;
    logic [DW-1:0] d;
    cyc++;
    if (!reset_l) begin
      model_clear();
      return;
    end
    e_pulse = '0; e_code = '0; e_amone = 1'b0;
    if (!enable) begin
      for (int c = 0; c < NCH; c++) m_busy[c] = 0;
      e_out = '0;
      return;
    end
    inc_e = 0; inc_d = 0;
    for (int c = 0; c < NCH; c++) begin
      code = 3'd0;
      d    = data[c*DW +: DW];
      age  = cyc - m_start[c];
      if (!m_busy[c]) begin
        if (req[c]) begin
          m_busy[c] = 1; m_start[c] = cyc; m_cap[c] = d; m_seen[c] = 0;
        end else if (ack[c]) code = 3'd1;
      end else if (ack[c]) begin
        if (age < MIN_LAT) code = 3'd3;
        else               inc_d++;
        if (req[c]) begin
          m_start[c] = cyc; m_cap[c] = d; m_seen[c] = 0;
        end else m_busy[c] = 0;
      end else if (age >= MAX_LAT) begin
        code = 3'd4; m_busy[c] = 0;
      end else if (req[c]) begin
        code = 3'd2;
      end else if (d != m_cap[c] && !m_seen[c]) begin
        code = 3'd5; m_seen[c] = 1;
      end
      e_pulse[c]       = (code != 3'd0);
      e_code[c*3 +: 3] = code;
      e_out[c]         = m_busy[c];
      if (code != 3'd0) inc_e++;
    end
    e_amone = ($countones(ack) > 1);
    if (e_amone) inc_e++;
    if (clr_err) begin
      e_sticky = e_pulse;
      e_err    = sat_val(inc_e, CNTW);
      e_err_s  = sat_val(inc_e, CNTW_S);
    end else begin
      e_sticky = e_sticky | e_pulse;
      e_err    = sat_val(e_err + inc_e, CNTW);
      e_err_s  = sat_val(e_err_s + inc_e, CNTW_S);
    end
    e_done   = sat_val(e_done + inc_d, CNTW);
    e_done_s = sat_val(e_done_s + inc_d, CNTW_S);
  endtask

  task automatic check_all();
    chk("outstanding", 64'(out_a), 64'(e_out));
    chk("err_pulse", 64'(pulse_a), 64'(e_pulse));
    chk("err_code", 64'(code_a), 64'(e_code));
    chk("err_sticky", 64'(sticky_a), 64'(e_sticky));
    chk("amone_err", 64'(amone_a), 64'(e_amone));
    chk("err_count", 64'(errc_a), 64'(e_err));
    chk("done_count", 64'(donec_a), 64'(e_done));
    chk("err_count_sat", 64'(errc_b), 64'(e_err_s));
    chk("done_count_sat", 64'(donec_b), 64'(e_done_s));
    chk("outstanding_b", 64'(out_b), 64'(e_out));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  int n5;

  initial begin
    model_clear();
    reset_l = 1'b0; enable = 1'b1; clr_err = 1'b0;
    req = '0; ack = '0; data = '0;
    step(); step();
    chk("rst_err_count", 64'(errc_a), 64'd0);
    reset_l = 1'b1;
    step();

    // legal transaction, ack three cycles after req
    req = 4'b0001; step();
    chk("d1_outstanding", 64'(out_a[0]), 64'd1);
    req = '0; step(); step();
    ack = 4'b0001; step();
    chk("d1_done", 64'(donec_a), 64'd1);
    chk("d1_no_pulse", 64'(pulse_a), 64'd0);
    ack = '0; step();

    // ack without req
    ack = 4'b0010; step();
    chk("d2_code", 64'(code_a[5:3]), 64'd1);
    chk("d2_err_count", 64'(errc_a), 64'd1);
    chk("d2_sticky", 64'(sticky_a[1]), 64'd1);
    ack = '0; step();

    // timeout after MAX_LAT cycles
    req = 4'b0100; step();
    req = '0;
    repeat (MAX_LAT - 1) step();
    step();
    chk("d3_timeout", 64'(code_a[8:6]), 64'd4);
    chk("d3_outstanding", 64'(out_a[2]), 64'd0);
    chk("d3_done", 64'(donec_a), 64'd1);

    // data changes while waiting: exactly one code 5
    n5 = 0;
    data[3*DW +: DW] = 32'hfeed; req = 4'b1000; step();
    req = '0; step();
    data[3*DW +: DW] = 32'hbeef; step();
    if (code_a[11:9] == 3'd5) n5++;
    step();
    if (code_a[11:9] == 3'd5) n5++;
    ack = 4'b1000; step();
    if (code_a[11:9] == 3'd5) n5++;
    chk("d4_single_chg", 64'(n5), 64'd1);
    chk("d4_done", 64'(donec_a), 64'd2);
    ack = '0; step();

    // two legal acks in one cycle with clr_err
    req = 4'b0101; step();
    req = '0; step();
    ack = 4'b0101; clr_err = 1'b1; step();
    chk("d5_amone", 64'(amone_a), 64'd1);
    chk("d5_err_count", 64'(errc_a), 64'd1);
    chk("d5_done", 64'(donec_a), 64'd4);
    ack = '0; clr_err = 1'b0; step();

    // back-to-back on ch0
    req = 4'b0001; step();
    req = '0; step();
    req = 4'b0001; ack = 4'b0001; step();
    chk("d6_b2b_out", 64'(out_a[0]), 64'd1);
    chk("d6_b2b_done", 64'(donec_a), 64'd5);
    req = '0; ack = '0; step();
    ack = 4'b0001; step();
    chk("d6_b2b_done2", 64'(donec_a), 64'd6);
    ack = '0; step();

    // early ack, double req, disable mid-transaction
    req = 4'b0010; step();
    req = '0; ack = 4'b0010; step();
    chk("d7_early", 64'(code_a[5:3]), 64'd3);
    ack = '0; req = 4'b0100; step();
    req = '0; step();
    req = 4'b0100; step();
    chk("d8_double", 64'(code_a[8:6]), 64'd2);
    req = '0; enable = 1'b0; step();
    chk("d9_disabled_out", 64'(out_a), 64'd0);
    enable = 1'b1; step();

    // five errors at once into a 2-bit counter
    ack = 4'b1111; clr_err = 1'b1; step();
    chk("d10_err_count", 64'(errc_a), 64'd5);
    chk("d10_err_sat", 64'(errc_b), 64'd3);
    ack = '0; clr_err = 1'b0; step();

    for (int i = 0; i < 1500; i++) begin
      reset_l = ($urandom_range(0, 299) != 0);
      enable  = ($urandom_range(0, 49) != 0);
      clr_err = ($urandom_range(0, 39) == 0);
      for (int c = 0; c < NCH; c++) begin
        req[c] = ($urandom_range(0, 5) == 0);
        ack[c] = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 15) == 0) data[c*DW +: DW] = $urandom();
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
